// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// The operand word is split into SEG-bit segments; each segment resolves in
// its own pipeline stage using 4-bit lookahead groups plus a second-level
// lookahead across the groups of the segment. The carry between segments
// travels through the stage registers. A valid/ready handshake stalls the
// whole pipeline when the consumer is not ready.
module cla_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             ovf,
    output logic             zero,
    output logic             GGo,
    output logic             PGo
);

    localparam int NSEG = WIDTH / SEG;
    localparam int NG   = SEG / 4;

    typedef struct packed {
        logic [SEG-1:0] s;
        logic           co;
        logic           gg;
        logic           pg;
    } seg_res_t;

    // One segment: 4-bit group lookahead, then a flat lookahead over the
    // groups (every group carry is a sum of products, no group-to-group chain).
    function automatic seg_res_t seg_cla(input logic [SEG-1:0] x,
                                         input logic [SEG-1:0] y,
                                         input logic           cin);
        seg_res_t     r;
        logic [SEG-1:0] p, g, c;
        logic [NG-1:0]  gp, gg;
        logic [NG:0]    gc;
        logic [3:0]     pj, gj;
        logic           acc, prod, pall, cj;
        p    = x ^ y;
        g    = x & y;
        acc  = 1'b0;
        pall = 1'b1;
        for (int j = 0; j < NG; j++) begin
            pj    = p[4*j +: 4];
            gj    = g[4*j +: 4];
            gp[j] = &pj;
            gg[j] = gj[3] | (pj[3] & gj[2]) | (pj[3] & pj[2] & gj[1])
                  | (pj[3] & pj[2] & pj[1] & gj[0]);
        end
        gc[0] = cin;
        for (int j = 1; j <= NG; j++) begin
            acc = 1'b0;
            for (int i = 0; i < j; i++) begin
                prod = gg[i];
                for (int m = i + 1; m < j; m++) begin
                    prod = prod & gp[m];
                end
                acc = acc | prod;
            end
            pall = 1'b1;
            for (int m = 0; m < j; m++) begin
                pall = pall & gp[m];
            end
            gc[j] = acc | (pall & cin);
        end
        // acc/pall now hold the whole-segment generate/propagate (j == NG)
        r.gg = acc;
        r.pg = pall;
        for (int j = 0; j < NG; j++) begin
            pj = p[4*j +: 4];
            gj = g[4*j +: 4];
            cj = gc[j];
            c[4*j]     = cj;
            c[4*j + 1] = gj[0] | (pj[0] & cj);
            c[4*j + 2] = gj[1] | (pj[1] & gj[0]) | (pj[1] & pj[0] & cj);
            c[4*j + 3] = gj[2] | (pj[2] & gj[1]) | (pj[2] & pj[1] & gj[0])
                       | (pj[2] & pj[1] & pj[0] & cj);
        end
        r.s  = p ^ c;
        r.co = gc[NG];
        return r;
    endfunction

    logic advance_s;

    genvar k;
    generate
        for (k = 0; k < NSEG; k++) begin : stg
            // RW: operand bits still unresolved entering this stage
            // LW: result bits resolved once this stage has registered
            localparam int RW = WIDTH - k * SEG;
            localparam int LW = (k + 1) * SEG;

            logic [RW-1:0] op_a_s;
            logic [RW-1:0] op_bx_s;
            logic          cin_s;
            logic          vin_s;
            seg_res_t      res_s;
            logic [LW-1:0] sum_s;
            logic          gg_s;
            logic          pg_s;

            logic          v_r;
            logic          c_r;
            logic          gg_r;
            logic          pg_r;
            logic [LW-1:0] s_r;

            if (k == 0) begin : g_first
                assign op_a_s  = a;
                assign op_bx_s = sub ? ~b : b;
                assign cin_s   = ci ^ sub;
                assign vin_s   = in_valid;
                assign sum_s   = res_s.s;
                assign gg_s    = res_s.gg;
                assign pg_s    = res_s.pg;
            end else begin : g_next
                assign op_a_s  = stg[k-1].g_fwd.a_r;
                assign op_bx_s = stg[k-1].g_fwd.bx_r;
                assign cin_s   = stg[k-1].c_r;
                assign vin_s   = stg[k-1].v_r;
                assign sum_s   = {res_s.s, stg[k-1].s_r};
                assign gg_s    = res_s.gg | (res_s.pg & stg[k-1].gg_r);
                assign pg_s    = res_s.pg & stg[k-1].pg_r;
            end

            assign res_s = seg_cla(op_a_s[SEG-1:0], op_bx_s[SEG-1:0], cin_s);

            // Stage register: segment sum, carry and running group terms move together
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_r  <= 1'b0;
                    c_r  <= 1'b0;
                    gg_r <= 1'b0;
                    pg_r <= 1'b0;
                    s_r  <= {LW{1'b0}};
                end else if (advance_s) begin
                    v_r  <= vin_s;
                    c_r  <= res_s.co;
                    gg_r <= gg_s;
                    pg_r <= pg_s;
                    s_r  <= sum_s;
                end
            end

            if (k < NSEG - 1) begin : g_fwd
                logic [RW-SEG-1:0] a_r;
                logic [RW-SEG-1:0] bx_r;

                // Delay the not-yet-resolved upper operand bits to the next stage
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_r  <= {(RW-SEG){1'b0}};
                        bx_r <= {(RW-SEG){1'b0}};
                    end else if (advance_s) begin
                        a_r  <= op_a_s[RW-1:SEG];
                        bx_r <= op_bx_s[RW-1:SEG];
                    end
                end
            end else begin : g_last
                logic ovf_s;
                logic zero_s;
                logic ovf_r;
                logic zero_r;

                // carry into the MSB is p[msb] ^ s[msb]
                assign ovf_s  = op_a_s[SEG-1] ^ op_bx_s[SEG-1] ^ res_s.s[SEG-1] ^ res_s.co;
                assign zero_s = (sum_s == {LW{1'b0}});

                // Register the word-level flags alongside the final sum
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ovf_r  <= 1'b0;
                        zero_r <= 1'b0;
                    end else if (advance_s) begin
                        ovf_r  <= ovf_s;
                        zero_r <= zero_s;
                    end
                end
            end
        end
    endgenerate

    // The pipeline moves as a unit whenever the output slot is free or drained
    assign advance_s = ~stg[NSEG-1].v_r | out_ready;
    assign in_ready  = advance_s;
    assign out_valid = stg[NSEG-1].v_r;
    assign S         = stg[NSEG-1].s_r;
    assign Co        = stg[NSEG-1].c_r;
    assign GGo       = stg[NSEG-1].gg_r;
    assign PGo       = stg[NSEG-1].pg_r;
    assign ovf       = stg[NSEG-1].g_last.ovf_r;
    assign zero      = stg[NSEG-1].g_last.zero_r;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: three instances (32/16, 16/4, 8/8) share the
// stimulus; directed vectors are checked against hand values on the 32-bit
// instance and every output of every instance is scored against a model.
module tb_cla_pipe_addsub;

    typedef logic [36:0] res_t;  // {pg, gg, zero, ovf, co, S[31:0]}

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        ci;
    logic        sub;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;

    logic [2:0]  ov;
    logic [2:0]  ir;
    logic [31:0] s0;
    logic [15:0] s1;
    logic [7:0]  s2;
    logic [2:0]  co, vf, zr, gg, pg;

    int n_checks = 0;
    int n_errors = 0;

    res_t q [3][$];
    int   cnt [3];
    int   first [3];
    int   last [3];

    logic [31:0] va [8] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_FFFF,
                            32'hDEAD_BEEF, 32'h0000_0000, 32'h7FFF_0001, 32'hAAAA_5555};
    logic [31:0] vb [8] = '{32'h0FED_CBA9, 32'h0000_0001, 32'h8000_0000, 32'h0001_0000,
                            32'h1111_2222, 32'h0000_0000, 32'h0000_FFFF, 32'h5555_AAAA};
    logic [7:0]  vci  = 8'b0110_1001;
    logic [7:0]  vsub = 8'b1010_0110;

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(32), .SEG(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready),
        .S(s0), .Co(co[0]), .ovf(vf[0]), .zero(zr[0]), .GGo(gg[0]), .PGo(pg[0]));

    cla_pipe_addsub #(.WIDTH(16), .SEG(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a[15:0]), .b(b[15:0]), .ci(ci), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready),
        .S(s1), .Co(co[1]), .ovf(vf[1]), .zero(zr[1]), .GGo(gg[1]), .PGo(pg[1]));

    cla_pipe_addsub #(.WIDTH(8), .SEG(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .a(a[7:0]), .b(b[7:0]), .ci(ci), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready),
        .S(s2), .Co(co[2]), .ovf(vf[2]), .zero(zr[2]), .GGo(gg[2]), .PGo(pg[2]));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int wid(input int i);
        return (i == 0) ? 32 : ((i == 1) ? 16 : 8);
    endfunction

    // Reference: plain wide arithmetic on the masked operands
    function automatic res_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                   input logic c, input logic s);
        logic [63:0] m, aa, bb, sum, gs;
        logic        o_co, o_ov, o_zr, o_pg, o_gg;
        m    = (64'd1 << w) - 64'd1;
        aa   = {32'd0, x} & m;
        bb   = (s ? ~{32'd0, y} : {32'd0, y}) & m;
        sum  = aa + bb + {63'd0, c ^ s};
        gs   = aa + bb;
        o_co = sum[w];
        o_ov = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
        o_zr = ((sum & m) == 64'd0);
        o_pg = ((aa ^ bb) == m);
        o_gg = gs[w];
        return {o_pg, o_gg, o_zr, o_ov, o_co, sum[31:0] & m[31:0]};
    endfunction

    function automatic res_t obs(input int i);
        case (i)
            0:       return {pg[0], gg[0], zr[0], vf[0], co[0], s0};
            1:       return {pg[1], gg[1], zr[1], vf[1], co[1], 16'd0, s1};
            default: return {pg[2], gg[2], zr[2], vf[2], co[2], 24'd0, s2};
        endcase
    endfunction

    // Scoreboard: push on acceptance, pop and compare on output transfer
    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) q[i].delete();
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (ov[i] && out_ready) begin
                    check_eq($sformatf("mon%0d_pending", i), 64'(q[i].size() != 0), 64'd1);
                    if (q[i].size() != 0) begin
                        e = q[i].pop_front();
                        check_eq($sformatf("mon%0d_result", i), 64'(obs(i)), 64'(e));
                    end
                end
                if (in_valid && ir[i]) q[i].push_back(model(wid(i), a, b, ci, sub));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
        a = x; b = y; ci = c; sub = s; in_valid = 1'b1;
    endtask

    // Wait (bounded) until the 32-bit instance accepts, then step past the edge
    task automatic wait_accept();
        int t;
        t = 0;
        @(negedge clk);
        while (!ir[0] && t < 50) begin
            t++;
            @(negedge clk);
        end
        check_eq("accept", 64'(ir[0]), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
        drive(x, y, c, s);
        wait_accept();
    endtask

    // Single operation into an empty pipeline: latency of each instance and hand values
    task automatic run_vec(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s,
                           input logic [31:0] es, input logic eco, input logic eov,
                           input logic ez, input logic egg, input logic epg);
        send(x, y, c, s);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("lat_w32", 64'(ov[0]), 64'(i == 1));
            check_eq("lat_w16", 64'(ov[1]), 64'(i == 3));
            check_eq("lat_w8",  64'(ov[2]), 64'(i == 0));
            if (i == 1) begin
                check_eq("vec_S",    64'(s0),    64'(es));
                check_eq("vec_Co",   64'(co[0]), 64'(eco));
                check_eq("vec_ovf",  64'(vf[0]), 64'(eov));
                check_eq("vec_zero", 64'(zr[0]), 64'(ez));
                check_eq("vec_GGo",  64'(gg[0]), 64'(egg));
                check_eq("vec_PGo",  64'(pg[0]), 64'(epg));
            end
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = 32'd0; b = 32'd0;
        ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_outputs", 64'(obs(0)), 64'd0);
        check_eq("rst_valid",   64'(ov), 64'd0);
        check_eq("rst_inready", 64'(ir[0]), 64'd1);
        rst_n = 1'b1;
        tick();

        // Directed vectors
        run_vec(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_vec(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        run_vec(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_vec(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Back-to-back: 8 operations, 8 consecutive results per instance
        for (int j = 0; j < 3; j++) begin cnt[j] = 0; first[j] = -1; last[j] = -1; end
        fork
            begin
                for (int i = 0; i < 8; i++) send(va[i], vb[i], vci[i], vsub[i]);
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    @(negedge clk);
                    for (int j = 0; j < 3; j++) begin
                        if (ov[j]) begin
                            if (first[j] < 0) first[j] = c;
                            last[j] = c;
                            cnt[j]++;
                        end
                    end
                end
            end
        join
        tick();
        for (int j = 0; j < 3; j++) begin
            check_eq("b2b_count", 64'(cnt[j]), 64'd8);
            check_eq("b2b_span",  64'(last[j] - first[j]), 64'd7);
        end
        idle_cycles(4);

        // Stall with a full pipeline
        out_ready = 1'b0;
        send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'd100, 32'd58, 1'b0, 1'b1);
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_inready", 64'(ir[0]), 64'd0);
            check_eq("stall_valid",   64'(ov[0]), 64'd1);
            check_eq("stall_hold",    64'(obs(0)),
                     64'(model(32, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0)));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        check_eq("release_inready", 64'(ir[0]), 64'd1);
        wait_accept();
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        in_valid = 1'b0;
        idle_cycles(10);
        for (int j = 0; j < 3; j++) check_eq("drain_empty", 64'(q[j].size()), 64'd0);

        // Reset with two operations in flight
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        send(32'h0F0F_0F0F, 32'h0000_0F0F, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid",   64'(ov), 64'd0);
        check_eq("midrst_outputs", 64'(obs(0)), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("postrst_idle", 64'(ov), 64'd0);
        end
        tick();
        run_vec(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(6);
        for (int j = 0; j < 3; j++) check_eq("final_empty", 64'(q[j].size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups with a second-level lookahead per segment. The operand word is split into SEG-bit segments, and each segment resolves in its own pipeline stage; the carry ripples between stages through registers. A valid/ready handshake with full-pipeline stall lets it sit in the datapath between operand-fetch and writeback logic. It adds subtract mode, signed overflow, zero detect, and whole-word group generate/propagate for cascading.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of SEG.
SEG, 16, bits resolved per pipeline stage; must be a multiple of 4. NSEG = WIDTH/SEG = latency in cycles.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
ci  input  1  carry-in (addition) / borrow modifier (subtraction)
sub  input  1  1 = subtract, 0 = add
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
S  output  WIDTH  sum/difference
Co  output  1  carry-out of MSB (in subtract mode, 1 = no borrow)
ovf  output  1  two's-complement signed overflow
zero  output  1  S == 0
GGo  output  1  group generate of the full word (operand-only, independent of ci)
PGo  output  1  group propagate of the full word

Behaviour:
- Reset (rst_n low, async): all stage valid bits clear; out_valid=0, S=0, Co=0, ovf=0, zero=0, GGo=0, PGo=0. Data registers are cleared too.
- Effective operand: bx = sub ? ~b : b. Effective carry-in: cin = ci ^ sub. With sub=1, ci=0 the result is a-b; with sub=1, ci=1 it is a-b-1.
- Per 4-bit group: p=a^bx, g=a&bx; group PG/GG and internal carries by 4-bit lookahead. Per segment: a second-level lookahead over the SEG/4 groups gives segment carries, segment PG and segment GG. Do not ripple across groups inside a segment.
- Stage k (0..NSEG-1) computes segment k's sum from a registered carry from stage k-1; stage 0 uses cin. Higher segments' operands are delay-registered until their stage.
- Running GGo/PGo are combined across stages: GG=GGk | (PGk & GGprev), PG=PGk & PGprev.
- Latency: an operand accepted at edge T produces out_valid=1 with its result after edge T+NSEG-1 when NSEG>1. For NSEG=1, results are registered once, so the latency is 1 cycle.
- Throughput: one operation per cycle with no bubbles when out_ready is held high.
- Handshake: advance = !out_valid | out_ready; in_ready = advance, which is combinational from out_ready. The whole pipeline shifts only when advance=1. A transfer happens when in_valid & in_ready. When advance=1 and in_valid=0, a bubble (valid=0) enters.
- While out_valid=1 and out_ready=0, S/Co/ovf/zero/GGo/PGo hold stable and no stage changes.
- ovf = carry into MSB XOR carry out of MSB. zero is computed on the final S.
- Simultaneous out_ready and in_valid with a full pipeline: output drains and input is accepted in the same cycle.
- rst_n asserted mid-operation drops all in-flight operations. There is no partial output after release; the first out_valid follows the first accepted input by the normal latency.
- Operands are not sampled when in_ready=0. The producer must hold them.

Test Plan:
- WIDTH=32, SEG=16: a=0x0000FFFF, b=0x00000001, sub=0, ci=0 -> S=0x00010000, Co=0, ovf=0, zero=0, out_valid exactly 2 cycles after acceptance (cross-segment carry).
- a=0x7FFFFFFF, b=1, add -> S=0x80000000, ovf=1, Co=0. Then a=5, b=5, sub=1, ci=0 -> S=0, zero=1, Co=1.
- a=3, b=5, sub=1, ci=1 -> S=0xFFFFFFFD (3-5-1), Co=0, ovf=0. a=0xFFFFFFFF, b=0, add -> PGo=1, GGo=0.
- Back-to-back 8 random operations with out_ready=1 -> 8 consecutive out_valid cycles, results match the a±b reference in order.
- Stall: hold out_ready=0 for 5 cycles with a full pipeline -> in_ready=0, outputs frozen. Release -> results drain in order, nothing lost or duplicated.
- Assert rst_n=0 mid-stream with 2 operations in flight -> out_valid=0 immediately and no stale results after release. Repeat the random suite for WIDTH=16, SEG=4 (latency 4) and WIDTH=8, SEG=8 (latency 1).
